// File: rtl/mx_fp32_block_collect.sv
// mx_fp32_block_collect
// Collects one MX block of BLOCK_SIZE FP32 elements from a valid/ready source,
// tracks the maximum biased exponent as the shared E8M0 scale, and replays the
// buffered elements in arrival order with the scale held for the whole block.
//
// State table:
//   COLLECT | accepting input elements; in_ready_o=1, out_valid_o=0
//   EMIT    | replaying buffered block; in_ready_o=0, out_valid_o=1
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid_i      upstream element valid
//   in_data_i       upstream FP32 element
//   in_ready_o      element accepted this cycle (COLLECT only)
//   out_valid_o     buffered element available (EMIT only)
//   out_data_o      buffered FP32 element, arrival order
//   out_scale_o     shared scale of the current block
//   out_first_o     out_data_o is element 0
//   out_last_o      out_data_o is element BLOCK_SIZE-1
//   out_ready_i     downstream accepts current element
//   scale_nan_o     current block scale is 0xFF
module mx_fp32_block_collect #(
  parameter int BLOCK_SIZE  = 32,
  parameter int FP32_WIDTH  = 32,
  parameter int SCALE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  input  logic [FP32_WIDTH-1:0]  in_data_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  output logic [FP32_WIDTH-1:0]  out_data_o,
  output logic [SCALE_WIDTH-1:0] out_scale_o,
  output logic                   out_first_o,
  output logic                   out_last_o,
  input  logic                   out_ready_i,
  output logic                   scale_nan_o
);

  localparam int IW = $clog2(BLOCK_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_SIZE - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          wr_idx_q, wr_idx_d;
  logic [IW-1:0]          rd_idx_q, rd_idx_d;
  logic [SCALE_WIDTH-1:0] run_max_q, run_max_d;
  logic [SCALE_WIDTH-1:0] scale_q, scale_d;
  logic                   nan_q, nan_d;
  logic [FP32_WIDTH-1:0]  buf_q [BLOCK_SIZE];

  logic                   emit;
  logic                   in_fire;
  logic                   out_fire;
  logic [SCALE_WIDTH-1:0] in_exp;
  logic [SCALE_WIDTH-1:0] new_max;

  assign emit     = (state_q == EMIT);
  assign in_fire  = in_valid_i && !emit;
  assign out_fire = emit && out_ready_i;

  // Biased exponent: zeros and subnormals give 0, Inf/NaN give all-ones,
  // so a plain max already saturates the scale to 0xFF for non-finite input.
  assign in_exp  = SCALE_WIDTH'(in_data_i[30:23]);
  assign new_max = (in_exp > run_max_q) ? in_exp : run_max_q;

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    run_max_d = run_max_q;
    scale_d   = scale_q;
    nan_d     = nan_q;
    if (in_fire) begin
      if (wr_idx_q == LAST_IDX) begin
        scale_d   = new_max;
        nan_d     = (new_max == '1);
        run_max_d = '0;
        wr_idx_d  = '0;
        rd_idx_d  = '0;
        state_d   = EMIT;
      end else begin
        run_max_d = new_max;
        wr_idx_d  = wr_idx_q + IW'(1);
      end
    end
    if (out_fire) begin
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d = '0;
        state_d  = COLLECT;
      end else begin
        rd_idx_d = rd_idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      run_max_q <= '0;
      scale_q   <= '0;
      nan_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      run_max_q <= run_max_d;
      scale_q   <= scale_d;
      nan_q     <= nan_d;
    end
  end

  // Element storage is deliberately not reset; a reset restarts collection
  // from index 0, so stale entries are always overwritten before replay.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_q[wr_idx_q] <= in_data_i;
    end
  end

  assign in_ready_o  = !emit;
  assign out_valid_o = emit;
  assign out_data_o  = emit ? buf_q[rd_idx_q] : '0;
  assign out_first_o = emit && (rd_idx_q == '0);
  assign out_last_o  = emit && (rd_idx_q == LAST_IDX);
  assign out_scale_o = scale_q;
  assign scale_nan_o = nan_q;

endmodule

// File: tb/tb_mx_fp32_block_collect.sv
// Directed testbench for mx_fp32_block_collect with BLOCK_SIZE=32.
module tb_mx_fp32_block_collect;

  logic        clk;
  logic        rst_n;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic [7:0]  out_scale_o;
  logic        out_first_o;
  logic        out_last_o;
  logic        out_ready_i;
  logic        scale_nan_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] blk [32];

  mx_fp32_block_collect #(
    .BLOCK_SIZE (32),
    .FP32_WIDTH (32),
    .SCALE_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_scale_o(out_scale_o),
    .out_first_o(out_first_o),
    .out_last_o (out_last_o),
    .out_ready_i(out_ready_i),
    .scale_nan_o(scale_nan_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready_o), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_data"},      out_data_o, 32'd0);
    chk({tag, "_scale"},     32'(out_scale_o), 32'd0);
    chk({tag, "_nan"},       32'(scale_nan_o), 32'd0);
    chk({tag, "_first"},     32'(out_first_o), 32'd0);
    chk({tag, "_last"},      32'(out_last_o), 32'd0);
  endtask

  // Offer blk[0..n-1]; each element must be accepted in its cycle.
  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid_i = 1'b1;
      in_data_i  = blk[i];
      #1;
      chk("send_in_ready", 32'(in_ready_o), 32'd1);
      chk("send_out_valid_low", 32'(out_valid_o), 32'd0);
      @(posedge clk);
    end
  endtask

  // Receive n elements, expecting blk[] in order. First check lands on the
  // cycle right after the final input handshake.
  task automatic recv(input int n, input bit stall, input bit hold_in,
                      input logic [31:0] hold_data, input logic [7:0] esc,
                      input bit enan);
    int i = 0;
    int cyc = 0;
    bit rdy;
    while (i < n && cyc < 400) begin
      @(negedge clk);
      in_valid_i  = hold_in;
      in_data_i   = hold_data;
      rdy         = stall ? (cyc % 3 == 0) : 1'b1;
      out_ready_i = rdy;
      #1;
      chk("recv_out_valid", 32'(out_valid_o), 32'd1);
      chk("recv_in_ready_low", 32'(in_ready_o), 32'd0);
      chk("recv_data", out_data_o, blk[i]);
      chk("recv_first", 32'(out_first_o), 32'(i == 0));
      chk("recv_last", 32'(out_last_o), 32'(i == 31));
      chk("recv_scale", 32'(out_scale_o), 32'(esc));
      chk("recv_nan", 32'(scale_nan_o), 32'(enan));
      @(posedge clk);
      if (rdy) i++;
      cyc++;
    end
    chk("recv_count", 32'(i), 32'(n));
  endtask

  initial begin
    rst_n       = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal block: all 1.0 except element 17 = 100.0 -> scale 0x85
    for (int i = 0; i < 32; i++) blk[i] = 32'h3F80_0000;
    blk[17] = 32'h42C8_0000;
    send(32);
    recv(32, 1'b0, 1'b0, 32'h0, 8'h85, 1'b0);

    // NaN block: random finite with e<=200, element 5 quiet NaN
    for (int i = 0; i < 32; i++)
      blk[i] = {1'($urandom), 8'($urandom_range(0, 200)), 23'($urandom)};
    blk[5] = 32'h7FC0_0000;
    send(32);
    recv(32, 1'b0, 1'b0, 32'h0, 8'hFF, 1'b1);

    // Zero / subnormal block
    for (int i = 0; i < 32; i++) begin
      case (i % 4)
        0: blk[i] = 32'h0000_0000;
        1: blk[i] = 32'h8000_0000;
        2: blk[i] = 32'h0000_0001;
        default: blk[i] = 32'h007F_FFFF;
      endcase
    end
    send(32);
    recv(32, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);

    // Backpressure: scale 0x85 block, stalled emit, next block already offered
    for (int i = 0; i < 32; i++) blk[i] = 32'h3F80_0000;
    blk[17] = 32'h42C8_0000;
    send(32);
    recv(32, 1'b1, 1'b1, 32'h3C00_0000, 8'h85, 1'b0);
    for (int i = 0; i < 32; i++) blk[i] = 32'h3C00_0000 | 32'(i);
    send(32);
    recv(32, 1'b0, 1'b0, 32'h0, 8'h78, 1'b0);

    // Reset after 10 inputs
    for (int i = 0; i < 32; i++) blk[i] = 32'h4000_0000 | 32'(i);
    send(10);
    @(negedge clk);
    in_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_collect");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) blk[i] = 32'h3F00_0000 + 32'(i);
    send(32);
    recv(32, 1'b0, 1'b0, 32'h0, 8'h7E, 1'b0);

    // Reset at rd_idx=7 of an Inf-scaled block
    for (int i = 0; i < 32; i++) blk[i] = 32'h3F80_0000 + 32'(i);
    blk[3] = 32'h7F80_0000;
    send(32);
    recv(7, 1'b0, 1'b0, 32'h0, 8'hFF, 1'b1);
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(out_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_emit");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) blk[i] = 32'h4120_0000 ^ (32'(i) << 4);
    send(32);
    recv(32, 1'b0, 1'b0, 32'h0, 8'h82, 1'b0);
    @(negedge clk);
    out_ready_i = 1'b0;
    #1;
    chk("end_in_ready", 32'(in_ready_o), 32'd1);
    chk("end_out_valid", 32'(out_valid_o), 32'd0);
    chk("end_scale_held", 32'(out_scale_o), 32'h82);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mx_fp32_block_collect.md
Name: mx_fp32_block_collect

Overview:
- Upstream stage of the MXINT8 block-data quantizer.
- Collects a block of BLOCK_SIZE FP32 elements from a streaming valid/ready source into a local buffer.
- Computes the block's shared E8M0 scale as the maximum biased exponent.
- Replays the buffered elements, one per handshake, to the quantizer with the scale held constant for the whole block.

Parameters:
- BLOCK_SIZE, 32, elements per MX block; power of two, range 2..64.
- FP32_WIDTH, 32, FP32 element width; fixed at 32.
- SCALE_WIDTH, 8, E8M0 shared-scale width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid_i  input  1  upstream element valid.
- in_data_i  input  FP32_WIDTH  upstream FP32 element.
- in_ready_o  output  1  block accepts an element this cycle.
- out_valid_o  output  1  element available to the quantizer.
- out_data_o  output  FP32_WIDTH  buffered FP32 element, in arrival order.
- out_scale_o  output  SCALE_WIDTH  shared scale of the current block.
- out_first_o  output  1  out_data_o is element 0 of the block.
- out_last_o  output  1  out_data_o is element BLOCK_SIZE-1 of the block.
- out_ready_i  input  1  quantizer accepts the current element.
- scale_nan_o  output  1  current block's scale is NaN (0xFF).

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=COLLECT; wr_idx=0, rd_idx=0, run_max=0.
  - Outputs: in_ready_o=1, out_valid_o=0, out_scale_o=0x00, scale_nan_o=0, out_first_o=0, out_last_o=0, out_data_o=0.
  - Buffer contents are not cleared.
  - Reset mid-block discards any partial or unemitted block. Nothing is emitted until a full new block has been collected.
- Exponent field: e = in_data_i[30:23]. Sign and mantissa are ignored for the scale.
  - Subnormals and ±0 contribute e=0.
  - e=0xFF (Inf or NaN) forces the block scale to 0xFF.
- COLLECT state:
  - in_ready_o=1, out_valid_o=0.
  - On in_valid_i&&in_ready_o: buf[wr_idx]<=in_data_i; run_max<=max(run_max,e); wr_idx increments.
  - Accepting wr_idx==BLOCK_SIZE-1:
    - out_scale_o<=max(run_max,e); scale_nan_o<=(that value==0xFF).
    - run_max<=0, wr_idx<=0, rd_idx<=0.
    - state<=EMIT.
  - If in_valid_i is low, no state change.
- EMIT state:
  - in_ready_o=0, out_valid_o=1.
  - out_data_o=buf[rd_idx].
  - out_first_o=(rd_idx==0); out_last_o=(rd_idx==BLOCK_SIZE-1).
  - On out_valid_o&&out_ready_i: rd_idx increments.
  - On the handshake with rd_idx==BLOCK_SIZE-1: rd_idx<=0, state<=COLLECT.
  - While out_valid_o&&!out_ready_i, out_data_o, out_first_o, out_last_o and out_scale_o hold stable.
- Latency: first output is valid the cycle after the last input handshake. No ready-to-valid combinational path on the input side.
- Timing of in_ready_o:
  - Returns to 1 the cycle after the final output handshake.
  - Throughput is one block per 2*BLOCK_SIZE cycles with no stalls.
  - in_ready_o is low for the entire EMIT phase, so an input offered during EMIT is not accepted and must be held by the source.
- out_scale_o:
  - Stays valid after EMIT ends until the next block's last input is accepted.
  - Changes only at the COLLECT→EMIT transition.
- Index counters are $clog2(BLOCK_SIZE) bits and wrap to 0 only via the explicit transitions above. There is no free-running wrap.
- No rounding, scale adjustment or mantissa processing here. Scale carry from rounding is handled downstream.

Test Plan:
- Normal block: 32 elements of 0x3F800000 (1.0, e=127), except element 17=0x42C80000 (100.0, e=133).
  - Required: scale 0x85; 32 outputs in order, bit-exact.
  - out_first_o on element 0 only, out_last_o on element 31 only.
  - First out_valid_o one cycle after the 32nd input handshake.
- NaN block: element 5=0x7FC00000, others random finite with e≤200.
  - Required: out_scale_o=0xFF, scale_nan_o=1; NaN element passed through unchanged.
- Zero/subnormal block: alternating 0x00000000, 0x80000000, 0x00000001, 0x007FFFFF.
  - Required: scale 0x00, scale_nan_o=0; all 32 elements output bit-exact.
- Backpressure: out_ready_i toggles 1,0,0,1,… during EMIT; in_valid_i held high throughout.
  - Required: outputs stable while stalled; in_ready_o=0 for all of EMIT.
  - No input accepted until the cycle after the 32nd output handshake.
  - Next block's scale computed with no carry-over of run_max from the previous block (previous scale 0x85, next block all e=120 → 0x78).
- Reset mid-operation:
  - Assert rst_n low after 10 inputs, then again at rd_idx=7 of EMIT.
  - Required: outputs immediately return to reset values asynchronously.
  - A fresh full block then emits with the correct scale and no stale elements.
